// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives a combinational-read
// instruction memory and registers the fetched word into the IF/ID stage.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] PC_LIMIT = 32'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] if_pc_nxt, if_instr_nxt;
  logic        if_valid_nxt;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign target    = {branch_addr[31:2], 2'b00};
  assign pc_inc    = pc + PC_STEP;
  assign imem_addr = pc;
  assign halted    = (state == HALT);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    if_pc_nxt    = if_pc;
    if_instr_nxt = if_instr;
    if_valid_nxt = if_valid;
    case (state)
      IDLE: begin
        if_valid_nxt = 1'b0;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        // Branch outranks the limit check and freeze; a frozen branch still flushes.
        if (branch_taken) begin
          pc_nxt       = target;
          if_valid_nxt = 1'b0;
          if_instr_nxt = '0;
          state_nxt    = (target < PC_LIMIT) ? FETCH : HALT;
        end else if (pc >= PC_LIMIT) begin
          if_valid_nxt = 1'b0;
          state_nxt    = HALT;
        end else if (!freeze) begin
          if_instr_nxt = imem_instr;
          if_pc_nxt    = pc_inc;
          if_valid_nxt = 1'b1;
          pc_nxt       = pc_inc;
        end
      end
      HALT: begin
        if (!freeze) if_valid_nxt = 1'b0;
        if (branch_taken) begin
          pc_nxt = target;
          if (target < PC_LIMIT) state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      if_pc    <= '0;
      if_instr <= '0;
      if_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      if_pc    <= if_pc_nxt;
      if_instr <= if_instr_nxt;
      if_valid <= if_valid_nxt;
    end
  end

endmodule
